hdmi_pll_sequencer: RTL and testbench
=====================================

HDMI_PLL_SEQUENCER -- requirements
Module: hdmi_pll_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_reset is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles allowed in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 4: failed attempts tolerated when the retry limit is compiled in.
REQ-005 SHALL have port clk  input  1: the single clock, 27 MHz crystal domain feeding the HDMI PLL.
REQ-006 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port pll_lock  input  1: raw PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port pll_reset  output  1: drives the PLL RESET pin.
REQ-009 SHALL have port hdmi_reset  output  1: active-high reset for the pixel/serializer domains.
REQ-010 SHALL have port ready  output  1: high only in RUN.
REQ-011 SHALL have port state  output  3: current state encoding.
REQ-012 SHALL have port retry_count  output  4: failed-attempt count, saturating at 15.
REQ-013 SHALL have port failed  output  1: sticky give-up flag.

Function
REQ-014 SHALL pass pll_lock through a 2-flop synchronizer; lock_s denotes its output (2-cycle latency); all decisions use lock_s only.
REQ-015 SHALL implement states PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4, with one shared down/up counter cnt.
REQ-016 SHALL, in PLL_RST, drive pll_reset=1, count PLL_RST_CYCLES cycles, then enter WAIT_LOCK with cnt cleared.
REQ-017 SHALL, in WAIT_LOCK, enter STABLE on lock_s=1; on cnt reaching LOCK_TIMEOUT-1 with lock_s=0, increment retry_count and enter PLL_RST.
REQ-018 SHALL, in STABLE, return to WAIT_LOCK (cnt cleared, no retry increment) on any lock_s=0; enter RUN after STABLE_CYCLES consecutive lock_s=1 cycles.
REQ-019 SHALL, in RUN, drive hdmi_reset=0 and ready=1; on lock_s=0, increment retry_count and enter PLL_RST next cycle.
REQ-020 SHALL drive hdmi_reset=1 in every state except RUN, with hdmi_reset and ready registered so both change on the same edge as state.
REQ-021 SHALL give a lock drop on the very cycle the timeout or STABLE count completes priority: a drop wins.
REQ-022 SHALL saturate retry_count at 15 and never wrap.
REQ-023 SHALL size cnt to $clog2 of the largest of the three cycle parameters plus 1.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set state=PLL_RST, cnt=0, retry_count=0, failed=0, pll_reset=1, hdmi_reset=1, ready=0, and synchronizer flops=0.
REQ-025 SHALL restart the full sequence from PLL_RST when reset is asserted mid-operation, including from RUN or FAIL.

Configuration
REQ-026 SHALL, with HDMI_PLL_RETRY_LIMIT_EN defined, enter FAIL instead of PLL_RST when an increment makes retry_count equal MAX_RETRIES.
REQ-027 SHALL, in FAIL, set failed=1, drive pll_reset=1 and hdmi_reset=1, and stay until reset.
REQ-028 SHALL, without HDMI_PLL_RETRY_LIMIT_EN, retry indefinitely, make FAIL unreachable, and tie failed to 0.

Structure
REQ-029 SHALL place the state enum (3-bit) and the default parameter constants in shared package hdmi_pll_pkg.
REQ-030 SHALL implement the 2-flop synchronizer as sub-module lock_sync, reset to 0 by the same synchronous reset.

Verification
REQ-031 SHALL cover: pll_lock raised 100 cycles after reset release, held -> pll_reset low at cycle 16, ready=1 exactly 256+2 cycles after lock rises, retry_count=0.
REQ-032 SHALL cover: pll_lock never rises -> PLL_RST entered every 16+1024 cycles, retry_count 1,2,3; with macro, failed=1 and state=4 after the 4th timeout; without macro, retry_count saturates at 15.
REQ-033 SHALL cover: lock glitches low for 1 cycle at STABLE count 200 -> back to WAIT_LOCK, retry_count unchanged, ready only 256 cycles after the glitch.
REQ-034 SHALL cover: in RUN, pll_lock drops -> hdmi_reset=1 and ready=0 within 3 cycles, retry_count=1, full relock sequence follows.
REQ-035 SHALL cover: reset pulsed while in RUN and while in FAIL -> all outputs take REQ-024 values on the next edge and failed clears.

Source files
------------

// File: rtl/hdmi_pll_pkg.sv
// Shared state encoding and default timing constants for the HDMI PLL sequencer.
// The retry limit is compiled in with HDMI_PLL_RETRY_LIMIT_EN.
package hdmi_pll_pkg;

  localparam int unsigned PLL_RST_CYCLES_DEF = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF   = 1024;
  localparam int unsigned STABLE_CYCLES_DEF  = 256;
  localparam int unsigned MAX_RETRIES_DEF    = 4;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hdmi_pll_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/hdmi_pll_sequencer.sv
// HDMI PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, releases HDMI reset.
// Define HDMI_PLL_RETRY_LIMIT_EN to give up (FAIL state) after MAX_RETRIES failed attempts.
module hdmi_pll_sequencer
  import hdmi_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               hdmi_reset,
  output logic               ready,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_count,
  output logic               failed
);

  localparam int unsigned CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

`ifdef HDMI_PLL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic               w_lock_s;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_retry_bump;
  logic               r_pll_reset;
  logic               r_hdmi_reset;
  logic               r_ready;
  logic               r_failed;
  logic               w_pll_reset_nxt;
  logic               w_hdmi_reset_nxt;
  logic               w_ready_nxt;
  logic               w_failed_nxt;

  lock_sync u_lock_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

  // Next-state, shared counter and retry bookkeeping; a lock drop always wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_retry_bump = 1'b0;
    w_retry_nxt  = r_retry;
    w_retry_inc  = (r_retry == RETRY_W'(15)) ? r_retry : r_retry + RETRY_W'(1);

    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // The detecting cycle is the first of the consecutive-lock run.
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_retry_bump = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_retry_bump = 1'b1;
        end
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_retry_bump) begin
      w_retry_nxt = w_retry_inc;
      w_cnt_nxt   = '0;
      if (LIMIT_EN && (w_retry_inc == RETRY_W'(MAX_RETRIES))) begin
        w_state_nxt = ST_FAIL;
      end else begin
        w_state_nxt = ST_PLL_RST;
      end
    end

    w_pll_reset_nxt  = (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAIL);
    w_hdmi_reset_nxt = (w_state_nxt != ST_RUN);
    w_ready_nxt      = (w_state_nxt == ST_RUN);
    w_failed_nxt     = LIMIT_EN && (r_failed || (w_state_nxt == ST_FAIL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_reset  <= 1'b1;
      r_hdmi_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_failed     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_reset  <= w_pll_reset_nxt;
      r_hdmi_reset <= w_hdmi_reset_nxt;
      r_ready      <= w_ready_nxt;
      r_failed     <= w_failed_nxt;
    end
  end

  assign state       = r_state;
  assign retry_count = r_retry;
  assign pll_reset   = r_pll_reset;
  assign hdmi_reset  = r_hdmi_reset;
  assign ready       = r_ready;
  assign failed      = r_failed;

endmodule

// File: tb/tb_hdmi_pll_sequencer.sv
// Scoreboard bench for hdmi_pll_sequencer: a phase/duration reference model predicts each
// output change; a negedge monitor pops and compares. Honours HDMI_PLL_RETRY_LIMIT_EN.
module tb_hdmi_pll_sequencer;

  localparam int P_RST = 16;
  localparam int LT    = 1024;
  localparam int SC    = 256;
  localparam int MAXR  = 4;
`ifdef HDMI_PLL_RETRY_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, hdmi_reset, ready, failed;
  logic [2:0] state;
  logic [3:0] retry_count;

  always #5 clk = ~clk;

  hdmi_pll_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .hdmi_reset  (hdmi_reset),
    .ready       (ready),
    .state       (state),
    .retry_count (retry_count),
    .failed      (failed)
  );

  typedef struct {
    int          cyc;
    logic [11:0] v;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rel = 0;

  // Reference model: phase 0..4, cycles spent in phase, run of consecutive lock samples.
  int          ph = 0, spent = 0, streak = 0, m_retry = 0;
  bit          s1 = 1'b0, s2 = 1'b0;
  logic [11:0] m_prev = 'x;
  logic [11:0] mon_prev = 'x;

  function automatic logic [11:0] exp_word(input int p, input int r);
    return {3'(p), (p == 0 || p == 4), (p != 3), (p == 3), 4'(r), (p == 4)};
  endfunction

  function automatic logic [11:0] dut_word();
    return {state, pll_reset, hdmi_reset, ready, retry_count, failed};
  endfunction

  task automatic model_attempt_failed();
    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    ph      = (LIM && m_retry == MAXR) ? 4 : 0;
  endtask

  always @(posedge clk) begin : model
    bit ls;
    int old;
    cyc = cyc + 1;
    if (reset) begin
      ph = 0; spent = 0; streak = 0; m_retry = 0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      ls  = s2;
      s2  = s1;
      s1  = pll_lock;
      old = ph;
      spent = spent + 1;
      case (ph)
        0: if (spent == P_RST) ph = 1;
        1: begin
          if (ls) begin ph = 2; streak = 1; end
          else if (spent == LT) model_attempt_failed();
        end
        2: begin
          if (!ls) ph = 1;
          else begin
            streak = streak + 1;
            if (streak >= SC) ph = 3;
          end
        end
        3: if (!ls) model_attempt_failed();
        default: ;
      endcase
      if (ph != old) spent = 0;
    end
    if (exp_word(ph, m_retry) !== m_prev) begin
      m_prev = exp_word(ph, m_retry);
      sb.push_back('{cyc, m_prev});
    end
  end

  always @(negedge clk) begin : monitor
    logic [11:0] act;
    exp_t e;
    act = dut_word();
    if (act !== mon_prev) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_unexpected: cycle %0d got %03h, no change expected", cyc, act);
      end else begin
        e = sb.pop_front();
        if (e.v !== act || e.cyc != cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_change: cycle %0d got %03h, expected %03h at cycle %0d",
                   cyc, act, e.v, e.cyc);
        end
      end
      mon_prev = act;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_checks = n_checks + 1;
    if (act != expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    rel = cyc;
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return ready;
      1:       return pll_reset;
      default: return hdmi_reset;
    endcase
  endfunction

  // Bounded wait for a level on ready/pll_reset/hdmi_reset; returns the cycle seen or -1.
  task automatic wait_sig(input int which, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_sig(which) === val) begin
        at = cyc;
        return;
      end
    end
    n_checks = n_checks + 1;
    n_fail   = n_fail + 1;
    $display("FAIL wait_timeout: signal %0d never reached %0b within %0d cycles", which, val, budget);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  initial begin : stim
    int t, t0, t1, r;
    // Cold start: lock rises 100 cycles after reset release.
    pll_lock = 1'b0;
    do_reset(3);
    wait_sig(1, 1'b0, 100, t);
    chk("pll_reset_release", t - rel, P_RST);
    wait_until(rel + 100);
    pll_lock = 1'b1;
    t0 = cyc;
    wait_sig(0, 1'b1, 400, t);
    chk("lock_to_ready", t - t0, SC + 2);
    chk("retry_after_lock", int'(retry_count), 0);

    // Lock lost while running.
    tick(5);
    pll_lock = 1'b0;
    t0 = cyc;
    wait_sig(0, 1'b0, 10, t);
    chk("run_drop_latency", t - t0, 3);
    chk("hdmi_reset_on_drop", int'(hdmi_reset), 1);
    chk("retry_on_drop", int'(retry_count), 1);
    tick(20);
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 1500, t);
    chk("relock_ready", int'(ready), 1);
    chk("retry_after_relock", int'(retry_count), 1);

    // Reset pulse while running.
    tick(3);
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    chk("reset_in_run", int'(dut_word()), int'(exp_word(0, 0)));
    reset = 1'b0;
    rel   = cyc;

    // Lock never arrives: one attempt per PLL_RST + LOCK_TIMEOUT cycles.
    for (int k = 1; k <= 3; k++) begin
      wait_until(rel + k * (P_RST + LT));
      chk("timeout_retry", int'(retry_count), k);
      chk("timeout_state", int'(state), 0);
    end
`ifdef HDMI_PLL_RETRY_LIMIT_EN
    wait_until(rel + MAXR * (P_RST + LT));
    chk("limit_state", int'(state), 4);
    chk("limit_failed", int'(failed), 1);
    tick(50);
    chk("fail_sticky", int'(state), 4);
`else
    wait_until(rel + 16 * (P_RST + LT) + 5);
    chk("retry_saturate", int'(retry_count), 15);
    chk("never_fail_state", int'(state == 3'd4), 0);
    chk("failed_tied", int'(failed), 0);
`endif
    reset = 1'b1;
    tick(1);
    chk("reset_late", int'(dut_word()), int'(exp_word(0, 0)));
    reset = 1'b0;
    rel   = cyc;

    // One-cycle glitch part way through the stable window.
    wait_until(rel + 50);
    pll_lock = 1'b1;
    t0 = cyc;
    wait_until(t0 + 202);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    t1 = cyc;
    wait_sig(0, 1'b1, 600, t);
    chk("glitch_relock_latency", t - t1, SC + 2);
    chk("glitch_retry", int'(retry_count), 0);

    // Randomized lock behaviour with occasional resets.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       do_reset($urandom_range(1, 3));
        1, 2, 3: begin pll_lock = 1'b1; tick($urandom_range(20, 400)); end
        4, 5, 6: begin pll_lock = 1'b0; tick($urandom_range(1, 3)); end
        7, 8:    begin pll_lock = 1'b0; tick($urandom_range(10, 1200)); end
        default: begin pll_lock = 1'b1; tick($urandom_range(250, 300)); end
      endcase
    end

    tick(10);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
